// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Multiply uses one registered product; divide is radix-2 restoring, one quotient bit per cycle.
`timescale 1ns/1ps
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            stall_req,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     quot_q, quot_d;
    logic [XLEN-1:0]     dvsr_q, dvsr_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic                special_q, special_d;
    logic [XLEN-1:0]     spec_res_q, spec_res_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                div_signed_s, a_neg_s, b_neg_s, div_zero_s, ovf_s;
    logic [XLEN-1:0]     a_mag_s, b_mag_s;
    logic                mul_a_sx_s, mul_b_sx_s;
    logic [2*XLEN-1:0]   mul_a_s, mul_b_s, mul_prod_s;
    logic [XLEN:0]       shifted_s, diff_s;
    logic                qbit_s;
    logic [XLEN-1:0]     rem_nx_s, quot_nx_s, quo_fix_s, rem_fix_s, final_s;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        negate = ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Operand decode at request time: magnitudes, signs and special-case detection.
    always_comb begin
        div_signed_s = ~op[0];
        a_neg_s      = div_signed_s & rs1[XLEN-1];
        b_neg_s      = div_signed_s & rs2[XLEN-1];
        a_mag_s      = a_neg_s ? negate(rs1) : rs1;
        b_mag_s      = b_neg_s ? negate(rs2) : rs2;
        div_zero_s   = (rs2 == {XLEN{1'b0}});
        ovf_s        = div_signed_s & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2);
        // Sign-extended 33-bit operands; the low 2*XLEN bits of the product are exact.
        mul_a_sx_s   = (op[1:0] != 2'b11) & rs1[XLEN-1];
        mul_b_sx_s   = (op[1] == 1'b0) & rs2[XLEN-1];
        mul_a_s      = {{XLEN{mul_a_sx_s}}, rs1};
        mul_b_s      = {{XLEN{mul_b_sx_s}}, rs2};
        mul_prod_s   = mul_a_s * mul_b_s;
    end

    // One restoring shift-subtract step plus the sign-corrected final result.
    always_comb begin
        shifted_s = {rem_q, quot_q[XLEN-1]};
        diff_s    = shifted_s - {1'b0, dvsr_q};
        qbit_s    = ~diff_s[XLEN];
        rem_nx_s  = qbit_s ? diff_s[XLEN-1:0] : shifted_s[XLEN-1:0];
        quot_nx_s = {quot_q[XLEN-2:0], qbit_s};
        quo_fix_s = neg_quo_q ? negate(quot_nx_s) : quot_nx_s;
        rem_fix_s = neg_rem_q ? negate(rem_nx_s) : rem_nx_s;
        if (special_q) begin
            final_s = spec_res_q;
        end else if (op_q[2]) begin
            final_s = op_q[1] ? rem_fix_s : quo_fix_s;
        end else if (op_q[1:0] == 2'b00) begin
            final_s = prod_q[XLEN-1:0];
        end else begin
            final_s = prod_q[2*XLEN-1:XLEN];
        end
    end

    // Next-state and datapath update for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        prod_d     = prod_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvsr_d     = dvsr_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;
        case (state_q)
            S_IDLE: begin
                if (req && !flush) begin
                    state_d    = S_BUSY;
                    op_d       = op;
                    prod_d     = mul_prod_s;
                    rem_d      = {XLEN{1'b0}};
                    quot_d     = a_mag_s;
                    dvsr_d     = b_mag_s;
                    neg_quo_d  = a_neg_s ^ b_neg_s;
                    neg_rem_d  = a_neg_s;
                    special_d  = op[2] & (div_zero_s | ovf_s);
                    if (div_zero_s) begin
                        spec_res_d = op[1] ? rs1 : {XLEN{1'b1}};
                    end else begin
                        spec_res_d = op[1] ? {XLEN{1'b0}} : rs1;
                    end
                    if (!op[2]) begin
                        cnt_d = CW'(MUL_CYCLES - 1);
                    end else if (div_zero_s || ovf_s) begin
                        cnt_d = {CW{1'b0}};
                    end else begin
                        cnt_d = CW'(XLEN - 1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                rem_d  = rem_nx_s;
                quot_d = quot_nx_s;
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == {CW{1'b0}}) begin
                    state_d  = S_DONE;
                    result_d = final_s;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                if (flush || !ex_stall) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CW{1'b0}};
            op_q       <= 3'b000;
            prod_q     <= {(2*XLEN){1'b0}};
            rem_q      <= {XLEN{1'b0}};
            quot_q     <= {XLEN{1'b0}};
            dvsr_q     <= {XLEN{1'b0}};
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= {XLEN{1'b0}};
            result_q   <= {XLEN{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            prod_q     <= prod_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvsr_q     <= dvsr_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
        end
    end

    // The request cycle itself must stall, so stall_req is combinational.
    assign stall_req    = ((state_q == S_IDLE) & req & ~flush) | (state_q == S_BUSY);
    assign result       = result_q;
    assign result_valid = (state_q == S_DONE);
    assign busy         = (state_q == S_BUSY);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver queues expected results, monitor checks them on result_valid.
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam int MULC = 1;
    localparam int DIV_STALLS = 33;
    localparam int SPC_STALLS = 2;
    localparam int MUL_STALLS = MULC + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        ex_stall;
    logic        flush;
    logic        stall_req;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;

    muldiv_unit #(.XLEN(32), .MUL_CYCLES(MULC)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .rs1(rs1), .rs2(rs2),
        .ex_stall(ex_stall), .flush(flush), .stall_req(stall_req),
        .result(result), .result_valid(result_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          stalls;
        int          at;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares each new result against the head of the scoreboard.
    exp_t        mon_e;
    logic        prev_valid = 1'b0;
    int          stall_run = 0;
    logic [31:0] held_res = 32'd0;
    always @(negedge clk) begin
        if (rst) begin
            stall_run  = 0;
            prev_valid = 1'b0;
        end else begin
            if (result_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h expected no result", result);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("result", result, mon_e.res);
                    check("stall_cycles", 32'(stall_run), 32'(mon_e.stalls));
                    check("result_cycle", 32'(cyc), 32'(mon_e.at));
                end
                held_res = result;
            end else if (result_valid) begin
                check("held_result", result, held_res);
                check("done_stall_req", 32'(stall_req), 32'd0);
            end
            if (stall_req) stall_run++;
            else stall_run = 0;
            prev_valid = result_valid;
        end
    end

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int stalls, input int hold);
        exp_t e;
        bit   seen;
        @(posedge clk); #1;
        op = o; rs1 = a; rs2 = b; req = 1'b1;
        e.res = exp; e.stalls = stalls; e.at = cyc + stalls;
        sb_q.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            rs1 = a ^ 32'h5A5A_A5A5;
            rs2 = ~b;
            if (result_valid) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: got no result_valid expected result %h", exp);
        end
        if (hold > 0) begin
            ex_stall = 1'b1;
            repeat (hold) begin @(posedge clk); #1; end
            ex_stall = 1'b0;
        end
        @(posedge clk); #1;
        req = 1'b0;
        check("leave_valid", 32'(result_valid), 32'd0);
        check("leave_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = 1'b0; op = 3'b000; rs1 = 32'd0; rs2 = 32'd0;
        ex_stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall_req", 32'(stall_req), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;

        do_op(3'b101, 32'd100, 32'd7, 32'd14, DIV_STALLS, 0);
        do_op(3'b111, 32'd100, 32'd7, 32'd2, DIV_STALLS, 0);
        do_op(3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, DIV_STALLS, 0);
        do_op(3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, DIV_STALLS, 0);
        do_op(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_STALLS, 0);
        do_op(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, DIV_STALLS, 0);
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_STALLS, 0);
        do_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, DIV_STALLS, 0);
        do_op(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, SPC_STALLS, 0);
        do_op(3'b110, 32'd5, 32'd0, 32'd5, SPC_STALLS, 0);
        do_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, SPC_STALLS, 0);
        do_op(3'b111, 32'd7, 32'd0, 32'd7, SPC_STALLS, 0);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_STALLS, 0);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPC_STALLS, 0);
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_STALLS, 0);
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_STALLS, 0);
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_STALLS, 0);
        do_op(3'b000, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFA, MUL_STALLS, 0);
        do_op(3'b000, 32'h0001_0000, 32'h0001_0000, 32'd0, MUL_STALLS, 0);
        do_op(3'b011, 32'h0001_0000, 32'h0001_0000, 32'd1, MUL_STALLS, 0);
        do_op(3'b001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_STALLS, 0);
        do_op(3'b010, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, MUL_STALLS, 0);
        do_op(3'b011, 32'h8000_0000, 32'd2, 32'd1, MUL_STALLS, 0);

        // Result held while EX is stalled, then released with no second result.
        do_op(3'b101, 32'd100, 32'd7, 32'd14, DIV_STALLS, 4);
        repeat (3) begin @(posedge clk); #1; check("post_hold_busy", 32'(busy), 32'd0); end

        // Flush mid-divide aborts; a following request restarts cleanly.
        @(posedge clk); #1;
        op = 3'b101; rs1 = 32'd100; rs2 = 32'd7; req = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        check("flush_cycle_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; req = 1'b0;
        check("flush_stall_req", 32'(stall_req), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_valid", 32'(result_valid), 32'd0);
        do_op(3'b111, 32'd100, 32'd7, 32'd2, DIV_STALLS, 0);

        // Flush coinciding with a new request in IDLE: no start.
        @(posedge clk); #1;
        op = 3'b101; rs1 = 32'd9; rs2 = 32'd3; req = 1'b1; flush = 1'b1;
        check("flush_req_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        check("flush_req_busy", 32'(busy), 32'd0);
        req = 1'b0; flush = 1'b0;

        // Asynchronous reset mid-divide returns to IDLE at once.
        @(posedge clk); #1;
        op = 3'b101; rs1 = 32'd1000; rs2 = 32'd3; req = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        req = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_stall_req", 32'(stall_req), 32'd0);
        check("arst_valid", 32'(result_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, DIV_STALLS, 0);

        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results: got %0d outstanding expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit in the EX stage.
- Sole source of the `muldiv_stall_req` signal consumed by the hazard detection unit. It holds IF/ID and bubbles EX until the result is ready, then releases the pipeline.
- Multiply uses a fixed-latency registered product. Divide/remainder uses a radix-2 restoring divider that produces one quotient bit per cycle.

Parameters:
- XLEN, 32, operand/result width.
- MUL_CYCLES, 1, wait cycles in BUSY for multiply ops (range 1..4).

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- req  input  1  EX holds a valid M-extension instruction
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  input  XLEN  operand A (post-forwarding)
- rs2  input  XLEN  operand B (post-forwarding)
- ex_stall  input  1  EX stage stalled by hazard unit (data bus busy)
- flush  input  1  EX flush (trap taken); aborts any operation
- stall_req  output  1  to hazard unit as muldiv_stall_req
- result  output  XLEN  final result, valid when result_valid=1
- result_valid  output  1  result available for the instruction currently in EX
- busy  output  1  state==BUSY

Behaviour:
- Reset values: state=IDLE, counter=0; stall_req, result_valid, busy = 0; result=0.
- States: IDLE, BUSY, DONE.
- stall_req = (state==IDLE & req & ~flush) | (state==BUSY). This is combinational so the request cycle itself stalls.
- IDLE:
  - req & ~flush: latch op/rs1/rs2 → BUSY.
  - Multiply: counter=MUL_CYCLES-1.
  - Divide: counter=XLEN-1, except the special cases below, which load counter=0.
- BUSY:
  - Multiply: full 33x33 signed product computed once at latch, registered. op selects the low word (MUL) or the high word (MULH/MULHSU/MULHU). Operand sign extension follows op (MULHSU: rs1 signed, rs2 unsigned).
  - Divide: one shift-subtract iteration per cycle on magnitudes.
  - counter==0 → DONE, with sign correction applied on entry:
    - quotient negative iff signed op and operand signs differ.
    - remainder takes the dividend's sign.
- Divide special cases, resolved without iterating (1 BUSY cycle):
  - Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- DONE:
  - result_valid=1, stall_req=0, result held stable.
  - ex_stall=1 → stay in DONE, result held.
  - else → IDLE. The instruction leaves EX this cycle, which prevents re-triggering on the same instruction.
- Latency (request accepted at cycle T):
  - Multiply: stall_req high T..T+MUL_CYCLES; result_valid at T+MUL_CYCLES+1.
  - Divide: stall_req high T..T+XLEN; result_valid at T+XLEN+1.
  - Special divide: stall_req high T..T+1; result_valid at T+2.
- flush in any state → IDLE next cycle, result_valid=0, no result produced. flush in the same cycle as a new req in IDLE: flush wins, no start, stall_req=0.
- Changes to req/op/rs1/rs2 while BUSY are ignored; operands are latched at start.
- Asynchronous reset mid-operation → IDLE immediately; partial state discarded.

Test Plan:
- DIVU rs1=100, rs2=7 → stall_req high 33 cycles; result_valid next cycle with result=14. REMU same operands → 2.
- DIV rs1=-100 (0xFFFFFF9C), rs2=7 → 0xFFFFFFF2 (-14). REM same operands → 0xFFFFFFFE (-2).
- DIV rs1=5, rs2=0 → 0xFFFFFFFF. REM rs1=5, rs2=0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM same operands → 0. For these: stall_req high 2 cycles, result at T+2.
- MULH 0x80000000 x 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF → 0xFFFFFFFE. MUL 3 x -2 → 0xFFFFFFFA. With MUL_CYCLES=1: stall 2 cycles, result at T+2.
- DIVU mid-iteration (cycle T+10) with flush=1 → IDLE next cycle, stall_req=0, no result_valid. A new req immediately after restarts with correct timing.
- Result ready while ex_stall=1 for 4 cycles → DONE held, result stable, stall_req=0. On ex_stall deassertion → IDLE one cycle later, no second computation.
